dsm_mash_serial: RTL and testbench

- Parametrised next-generation serially-programmed delta-sigma modulator for the frac-N divider control path.
- Runs entirely in the clk_dsm domain. The serial port (sclk/sdata/en) is oversampled and edge-detected inside the block rather than clocked by sclk.
- Frame carries a WIDTH-bit fractional word plus a 2-bit order field, selecting a MASH 1, 1-1 or 1-1-1 modulator.
- Multi-bit signed output feeds the divider-modulus adder.

---
 rtl/dsm_mash_serial.sv | 237 +++++++++++++++++++++++
 tb/tb_dsm_mash_serial.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_mash_serial.sv
// -----------------------------------------------------------------------------
// dsm_mash_serial
// Serially programmed MASH delta-sigma modulator for the frac-N divider control
// path. All logic runs on clk_dsm. The serial port (sclk/sdata/en) is
// oversampled: each line passes a synchroniser chain, and edges are detected on
// the synchronised copies, so sclk is never used as a clock.
//
// A frame is WIDTH+2 bits, MSB first: order[1:0] then the fractional word.
// A frame of any other length is dropped and flags frm_err.
// order 0 = idle (dout = 0), 1 = MASH 1, 2 = MASH 1-1, 3 = MASH 1-1-1.
//
// Parameters:
//   WIDTH       : fractional word / accumulator width (4..24)
//   SYNC_STAGES : synchroniser depth on sclk, sdata, en (2..3)
//
// Ports:
//   clk_dsm : modulator and interface clock
//   rst     : asynchronous active-high reset
//   sclk    : serial bit clock (sampled)
//   sdata   : serial data, valid at the sclk rising edge
//   en      : frame enable, the falling edge ends the frame
//   dout    : signed modulator output, -3..+4, one cycle after the carries
//   cfg_ok  : one-cycle pulse when a frame is committed
//   frm_err : sticky bad-length flag, cleared by the next good commit
//
// Optional feature (macro DSM_DITHER_EN): a 15-bit LFSR (x^15+x^14+1, seed 1)
// injects its bit 0 as carry-in to stage 1 while order is 3.
// -----------------------------------------------------------------------------
module dsm_mash_serial #(
  parameter int WIDTH       = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_dsm,
  input  logic              rst,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              en,
  output logic signed [3:0] dout,
  output logic              cfg_ok,
  output logic              frm_err
);

  localparam int FRAME_BITS = WIDTH + 2;
  localparam int CNT_W      = $clog2(WIDTH + 4);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 3);

  // ---------------------------------------------------------------------------
  // Input synchronisers: bit 2 = sclk, bit 1 = sdata, bit 0 = en
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [2:0] q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_dsm or posedge rst) begin
          if (rst) q <= '0;
          else     q <= {sclk, sdata, en};
        end
      end else begin : g_next
        always_ff @(posedge clk_dsm or posedge rst) begin
          if (rst) q <= '0;
          else     q <= g_sync[gi-1].q;
        end
      end
    end
  endgenerate

  logic sclk_s, sdata_s, en_s;
  assign {sclk_s, sdata_s, en_s} = g_sync[SYNC_STAGES-1].q;

  logic sclk_d_reg, en_d_reg;
  logic sclk_rise, en_rise, en_fall, shift_en;

  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign en_rise   = en_s & ~en_d_reg;
  assign en_fall   = ~en_s & en_d_reg;
  // A bit clocked in on the very cycle en drops still belongs to the frame.
  assign shift_en  = sclk_rise & (en_s | en_fall);

  // ---------------------------------------------------------------------------
  // Shift register, bit counter and frame-end decision
  // ---------------------------------------------------------------------------
  logic [FRAME_BITS-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]      bitcnt_reg, bitcnt_next, cnt_base;
  logic                  frame_good, frame_bad;

  always_comb begin
    shift_next  = shift_reg;
    cnt_base    = en_rise ? '0 : bitcnt_reg;
    bitcnt_next = cnt_base;
    if (shift_en) begin
      shift_next = {shift_reg[FRAME_BITS-2:0], sdata_s};
      if (cnt_base != CNT_SAT) bitcnt_next = cnt_base + CNT_W'(1);
    end
    frame_good = en_fall && (bitcnt_next == CNT_FULL);
    frame_bad  = en_fall && (bitcnt_next != CNT_FULL);
  end

  logic                  pend_reg;
  logic [FRAME_BITS-1:0] pend_frame_reg;
  logic [1:0]            pend_order;
  logic [WIDTH-1:0]      pend_word;

  assign pend_order = pend_frame_reg[FRAME_BITS-1 -: 2];
  assign pend_word  = pend_frame_reg[WIDTH-1:0];

  always_ff @(posedge clk_dsm or posedge rst) begin
    if (rst) begin
      sclk_d_reg     <= 1'b0;
      en_d_reg       <= 1'b0;
      shift_reg      <= '0;
      bitcnt_reg     <= '0;
      pend_reg       <= 1'b0;
      pend_frame_reg <= '0;
    end else begin
      sclk_d_reg <= sclk_s;
      en_d_reg   <= en_s;
      shift_reg  <= shift_next;
      bitcnt_reg <= bitcnt_next;
      if (frame_good) begin
        pend_frame_reg <= shift_next;
        pend_reg       <= 1'b1;
      end else begin
        pend_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Active settings and the modulator datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] di_reg;
  logic [1:0]       order_reg;
  logic [WIDTH-1:0] acc1_reg, acc2_reg, acc3_reg;
  logic [WIDTH-1:0] acc1_next, acc2_next, acc3_next;
  logic             c2d_reg, c3d_reg, c3dd_reg;
  logic             c2d_next, c3d_next, c3dd_next;
  logic             cfg_ok_reg, frm_err_reg;
  logic [3:0]       dout_reg, y;

  logic             use1, use2, use3, dither_bit;
  logic [WIDTH:0]   sum1, sum2, sum3;
  logic             c1, c2, c3;
  logic             order_change;

  assign use1 = (order_reg != 2'd0);
  assign use2 = (order_reg >= 2'd2);
  assign use3 = (order_reg == 2'd3);

`ifdef DSM_DITHER_EN
  logic [14:0] lfsr_reg;
  always_ff @(posedge clk_dsm or posedge rst) begin
    if (rst) lfsr_reg <= 15'h1;
    else     lfsr_reg <= {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};
  end
  assign dither_bit = use3 & lfsr_reg[0];
`else
  assign dither_bit = 1'b0;
`endif

  // Stage n+1 accumulates the fresh residue of stage n (combinational chain).
  assign sum1 = {1'b0, acc1_reg} + {1'b0, di_reg} + {{WIDTH{1'b0}}, dither_bit};
  assign sum2 = {1'b0, acc2_reg} + {1'b0, sum1[WIDTH-1:0]};
  assign sum3 = {1'b0, acc3_reg} + {1'b0, sum2[WIDTH-1:0]};

  // Unused stages contribute no carries, so their taps drain to zero.
  assign c1 = use1 & sum1[WIDTH];
  assign c2 = use2 & sum2[WIDTH];
  assign c3 = use3 & sum3[WIDTH];

  assign order_change = pend_reg && (pend_order != order_reg);

  always_comb begin
    // Noise-cancellation network; 4-bit wrap arithmetic gives the signed result.
    y = '0;
    if (use1) begin
      y = {3'b0, c1} + {3'b0, c2} - {3'b0, c2d_reg}
        + {3'b0, c3} - {2'b0, c3d_reg, 1'b0} + {3'b0, c3dd_reg};
    end

    acc1_next = use1 ? sum1[WIDTH-1:0] : acc1_reg;
    acc2_next = use2 ? sum2[WIDTH-1:0] : '0;
    acc3_next = use3 ? sum3[WIDTH-1:0] : '0;
    c2d_next  = c2;
    c3d_next  = c3;
    c3dd_next = c3d_reg;

    // A new order restarts the modulator from a clean state; a word-only
    // change keeps the accumulators so the output phase is continuous.
    if (order_change) begin
      acc1_next = '0;
      acc2_next = '0;
      acc3_next = '0;
      c2d_next  = 1'b0;
      c3d_next  = 1'b0;
      c3dd_next = 1'b0;
    end
  end

  always_ff @(posedge clk_dsm or posedge rst) begin
    if (rst) begin
      di_reg      <= '0;
      order_reg   <= 2'd0;
      acc1_reg    <= '0;
      acc2_reg    <= '0;
      acc3_reg    <= '0;
      c2d_reg     <= 1'b0;
      c3d_reg     <= 1'b0;
      c3dd_reg    <= 1'b0;
      dout_reg    <= '0;
      cfg_ok_reg  <= 1'b0;
      frm_err_reg <= 1'b0;
    end else begin
      acc1_reg   <= acc1_next;
      acc2_reg   <= acc2_next;
      acc3_reg   <= acc3_next;
      c2d_reg    <= c2d_next;
      c3d_reg    <= c3d_next;
      c3dd_reg   <= c3dd_next;
      dout_reg   <= y;
      cfg_ok_reg <= pend_reg;
      if (pend_reg) begin
        di_reg      <= pend_word;
        order_reg   <= pend_order;
        frm_err_reg <= 1'b0;
      end else if (frame_bad) begin
        frm_err_reg <= 1'b1;
      end
    end
  end

  assign dout    = dout_reg;
  assign cfg_ok  = cfg_ok_reg;
  assign frm_err = frm_err_reg;

endmodule

// File: tb/tb_dsm_mash_serial.sv
// -----------------------------------------------------------------------------
// tb_dsm_mash_serial
// Directed frames drive the serial port; a cycle-level reference model of the
// MASH modulator (integer accumulators, carries by division) predicts dout,
// cfg_ok and frm_err on every cycle. Hand-computed literals pin the model:
// the first dout samples after commit, window sums and output ranges.
// -----------------------------------------------------------------------------
module tb_dsm_mash_serial;

  localparam int W  = 9;
  localparam int S  = 2;
  localparam int FB = W + 2;
  localparam int HALF = 4;  // sclk half-period in clk_dsm cycles

  logic              clk_dsm = 1'b0;
  logic              rst = 1'b0;
  logic              sclk = 1'b0;
  logic              sdata = 1'b0;
  logic              en = 1'b0;
  logic signed [3:0] dout;
  logic              cfg_ok;
  logic              frm_err;

  dsm_mash_serial #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk_dsm (clk_dsm),
    .rst     (rst),
    .sclk    (sclk),
    .sdata   (sdata),
    .en      (en),
    .dout    (dout),
    .cfg_ok  (cfg_ok),
    .frm_err (frm_err)
  );

  always #5 clk_dsm = ~clk_dsm;

  int cyc = 0;
  always @(posedge clk_dsm) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_range(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d..%0d (cycle %0d)", name, actual, lo, hi, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: advanced once per clock, evaluated at the falling edge
  // ---------------------------------------------------------------------------
  int m_acc1, m_acc2, m_acc3, m_di, m_order;
  int m_c2d, m_c3d, m_c3dd, m_dout;
  bit m_cfg, m_err;
  int commit_at = -1, err_at = -1, sched_order, sched_di;
  bit chk_en = 1'b0;

  task automatic model_reset();
    m_acc1 = 0; m_acc2 = 0; m_acc3 = 0; m_di = 0; m_order = 0;
    m_c2d = 0; m_c3d = 0; m_c3dd = 0; m_dout = 0;
    m_cfg = 0; m_err = 0; commit_at = -1; err_at = -1;
  endtask

  task automatic model_step();
    int modv, s1, s2, s3, c1, c2, c3, y;
    modv = 1 << W;
    c1 = 0; c2 = 0; c3 = 0; s1 = m_acc1; s2 = 0; s3 = 0;
    if (m_order >= 1) begin s1 = m_acc1 + m_di; c1 = s1 / modv; s1 = s1 % modv; end
    if (m_order >= 2) begin s2 = m_acc2 + s1;   c2 = s2 / modv; s2 = s2 % modv; end
    if (m_order == 3) begin s3 = m_acc3 + s2;   c3 = s3 / modv; s3 = s3 % modv; end
    case (m_order)
      1:       y = c1;
      2:       y = c1 + c2 - m_c2d;
      3:       y = c1 + c2 - m_c2d + c3 - 2 * m_c3d + m_c3dd;
      default: y = 0;
    endcase
    m_dout = y;
    m_acc1 = s1;
    m_acc2 = s2;
    m_acc3 = s3;
    m_c3dd = m_c3d;
    m_c3d  = c3;
    m_c2d  = c2;
    m_cfg  = 0;
    if (cyc == err_at) m_err = 1;
    if (cyc == commit_at) begin
      m_cfg = 1;
      m_err = 0;
      if (sched_order != m_order) begin
        m_acc1 = 0; m_acc2 = 0; m_acc3 = 0; m_c2d = 0; m_c3d = 0; m_c3dd = 0;
      end
      m_order = sched_order;
      m_di    = sched_di;
    end
  endtask

  always @(negedge clk_dsm) begin
    if (rst) model_reset();
    else     model_step();
    if (chk_en) begin
      check("dout_vs_model", int'(dout), m_dout);
      check("cfg_ok_vs_model", int'(cfg_ok), int'(m_cfg));
      check("frm_err_vs_model", int'(frm_err), int'(m_err));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk_dsm);
    #2;
  endtask

  task automatic send_frame(input int nbits, input logic [31:0] val, input bit good,
                            input int ord, input int di);
    en = 1'b1;
    tick(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdata = val[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    if (good) begin
      sched_order = ord;
      sched_di    = di;
      commit_at   = cyc + S + 2;
    end else begin
      err_at = cyc + S + 1;
    end
    en = 1'b0;
    if (good) begin
      for (int k = 0; k < 20 && cyc < commit_at; k++) tick(1);
    end else begin
      tick(S + 4);
    end
    $display("frame bits=%0d val=0x%0h good=%0d -> cfg_ok=%0d frm_err=%0d dout=%0d",
             nbits, val, good, cfg_ok, frm_err, dout);
  endtask

  task automatic window(input int n, output int sum, output int mn, output int mx);
    sum = 0; mn = 100; mx = -100;
    for (int i = 0; i < n; i++) begin
      tick(1);
      sum += int'(dout);
      if (int'(dout) < mn) mn = int'(dout);
      if (int'(dout) > mx) mx = int'(dout);
    end
  endtask

  task automatic seq_0101(input string tag);
    // From a zero accumulator with DI = 256: 0 (commit edge), 0, then 1,0,1
    check({tag, "_cfg_ok"}, int'(cfg_ok), 1);
    check({tag, "_d0"}, int'(dout), 0);
    tick(1); check({tag, "_d1"}, int'(dout), 0);
    check({tag, "_cfg_once"}, int'(cfg_ok), 0);
    tick(1); check({tag, "_d2"}, int'(dout), 1);
    tick(1); check({tag, "_d3"}, int'(dout), 0);
    tick(1); check({tag, "_d4"}, int'(dout), 1);
  endtask

  int sum, mn, mx;

  initial begin
    // Reset
    rst = 1'b1;
    #2;
    chk_en = 1'b1;
    tick(3);
    check("rst_dout", int'(dout), 0);
    check("rst_cfg_ok", int'(cfg_ok), 0);
    check("rst_frm_err", int'(frm_err), 0);
    rst = 1'b0;
    tick(5);

    // Order 1, DI 256
    send_frame(FB, {2'd1, 9'd256}, 1'b1, 1, 256);
    check("o1_order", int'(dut.order_reg), 1);
    seq_0101("o1");
    tick(7);

    // Word-only change: continuity checked by the model
    send_frame(FB, {2'd1, 9'd257}, 1'b1, 1, 257);
    tick(30);

    // DI = 0: output stays at 0
    send_frame(FB, {2'd1, 9'd0}, 1'b1, 1, 0);
    window(40, sum, mn, mx);
    check("di0_min", mn, 0);
    check("di0_max", mx, 0);

    // DI = 511: 511 ones in any 512-cycle window
    send_frame(FB, {2'd1, 9'd511}, 1'b1, 1, 511);
    window(512, sum, mn, mx);
    check("di511_sum", sum, 511);
    $display("order1 DI=511 sum=%0d min=%0d max=%0d", sum, mn, mx);

    // Bad-length frames: 10 bits then 12 bits
    send_frame(10, 32'h155, 1'b0, 0, 0);
    check("bad10_frm_err", int'(frm_err), 1);
    check("bad10_order", int'(dut.order_reg), 1);
    tick(10);
    send_frame(12, 32'hABC, 1'b0, 0, 0);
    check("bad12_frm_err", int'(frm_err), 1);
    tick(10);

    // Order 1 -> 2, DI 100: accumulators cleared on commit, frm_err cleared
    send_frame(FB, {2'd2, 9'd100}, 1'b1, 2, 100);
    check("o2_acc1_clr", int'(dut.acc1_reg), 0);
    check("o2_acc2_clr", int'(dut.acc2_reg), 0);
    check("o2_acc3_clr", int'(dut.acc3_reg), 0);
    check("o2_frm_err_clr", int'(frm_err), 0);
    window(512, sum, mn, mx);
    check_range("o2_sum", sum, 99, 101);
    check_range("o2_min", mn, -1, 2);
    check_range("o2_max", mx, -1, 2);
    $display("order2 DI=100 sum=%0d min=%0d max=%0d", sum, mn, mx);

    // Order 3, DI 100
    send_frame(FB, {2'd3, 9'd100}, 1'b1, 3, 100);
    window(512, sum, mn, mx);
    check_range("o3_sum", sum, 97, 103);
    check_range("o3_min", mn, -3, 4);
    check_range("o3_max", mx, -3, 4);
    $display("order3 DI=100 sum=%0d min=%0d max=%0d", sum, mn, mx);

    // Reset after 5 frame bits
    en = 1'b1;
    tick(HALF);
    for (int i = 0; i < 5; i++) begin
      sdata = i[0];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    rst = 1'b1;
    en = 1'b0;
    sdata = 1'b0;
    tick(3);
    check("midrst_dout", int'(dout), 0);
    check("midrst_order", int'(dut.order_reg), 0);
    check("midrst_cfg_ok", int'(cfg_ok), 0);
    rst = 1'b0;
    tick(12);
    check("midrst_dout_idle", int'(dout), 0);
    $display("mid-frame reset: dout=%0d order=%0d", dout, dut.order_reg);

    // Fresh frame after reset commits normally
    send_frame(FB, {2'd1, 9'd256}, 1'b1, 1, 256);
    seq_0101("post_rst");
    tick(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
